// File: rtl/sram_pkg.sv
// Shared types for the two-master SRAM arbiter: master ids and the
// byte-enable value that marks a lane as "not written" (all lanes = read).
package sram_pkg;

  typedef enum logic {
    M_DATA = 1'b0,
    M_INST = 1'b1
  } master_id_e;

  localparam logic WE_READ = 1'b0;

endpackage

// File: rtl/arb_pick2.sv
// Two-requester grant picker: a lone requester always wins; on conflict the
// master named by prio wins. Purely combinational.
module arb_pick2
  import sram_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  master_id_e prio,
  output logic       gnt0,
  output logic       gnt1
);

  always_comb begin
    gnt0 = req0 && (!req1 || (prio == M_DATA));
    gnt1 = req1 && (!req0 || (prio == M_INST));
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates a data master (m0) and an instruction master (m1) onto one
// 1-cycle-latency SRAM. Define SRAM_ARBITER_RR_EN for round-robin conflicts;
// otherwise m0 always wins.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int LEN_ADDR = 64,
  parameter int LEN_DATA = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_ena,
  input  logic [LEN_ADDR-1:0]   m0_addra,
  input  logic [LEN_DATA-1:0]   m0_dina,
  input  logic [LEN_DATA/8-1:0] m0_wea,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [LEN_DATA-1:0]   m0_douta,
  input  logic                  m1_ena,
  input  logic [LEN_ADDR-1:0]   m1_addra,
  input  logic [LEN_DATA-1:0]   m1_dina,
  input  logic [LEN_DATA/8-1:0] m1_wea,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [LEN_DATA-1:0]   m1_douta,
  output logic [LEN_ADDR-1:0]   s_addra,
  output logic [LEN_DATA-1:0]   s_dina,
  output logic                  s_ena,
  output logic [LEN_DATA/8-1:0] s_wea,
  input  logic [LEN_DATA-1:0]   s_douta
);

  localparam int LEN_WE = LEN_DATA / 8;

  logic                     resp_pend_q, resp_pend_d;
  master_id_e               resp_owner_q, resp_owner_d;
  logic [1:0][LEN_DATA-1:0] douta_hold_q, douta_hold_d;
  logic                     req0, req1, pick0, pick1;
  master_id_e               prio;

`ifdef SRAM_ARBITER_RR_EN
  master_id_e last_gnt_q, last_gnt_d;

  // The master that did not win most recently gets priority on a conflict.
  assign prio = (last_gnt_q == M_DATA) ? M_INST : M_DATA;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (pick0)      last_gnt_d = M_DATA;
    else if (pick1) last_gnt_d = M_INST;
  end

  always_ff @(posedge clk) begin
    if (rst) last_gnt_q <= M_INST;
    else     last_gnt_q <= last_gnt_d;
  end
`else
  assign prio = M_DATA;
`endif

  assign req0 = m0_ena && !rst;
  assign req1 = m1_ena && !rst;

  arb_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .prio (prio),
    .gnt0 (pick0),
    .gnt1 (pick1)
  );

  always_comb begin
    m0_gnt  = pick0;
    m1_gnt  = pick1;
    s_ena   = (m0_ena || m1_ena) && !rst;
    s_addra = '0;
    s_dina  = '0;
    s_wea   = '0;
    if (pick0) begin
      s_addra = m0_addra;
      s_dina  = m0_dina;
      s_wea   = m0_wea;
    end else if (pick1) begin
      s_addra = m1_addra;
      s_dina  = m1_dina;
      s_wea   = m1_wea;
    end

    // Only a granted read expects data back on the next cycle.
    resp_pend_d  = (pick0 || pick1) && (s_wea == {LEN_WE{WE_READ}});
    resp_owner_d = pick1 ? M_INST : M_DATA;

    m0_rvalid = resp_pend_q && (resp_owner_q == M_DATA) && !rst;
    m1_rvalid = resp_pend_q && (resp_owner_q == M_INST) && !rst;

    douta_hold_d    = douta_hold_q;
    if (m0_rvalid) douta_hold_d[0] = s_douta;
    if (m1_rvalid) douta_hold_d[1] = s_douta;
    m0_douta = m0_rvalid ? s_douta : douta_hold_q[0];
    m1_douta = m1_rvalid ? s_douta : douta_hold_q[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_pend_q  <= 1'b0;
      resp_owner_q <= M_DATA;
      douta_hold_q <= '0;
    end else begin
      resp_pend_q  <= resp_pend_d;
      resp_owner_q <= resp_owner_d;
      douta_hold_q <= douta_hold_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed vectors push expected read
// responses; a monitor pops them when rvalid is due and tracks douta holds.
module tb_sram_arbiter;

`ifdef SRAM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_ena, m1_ena;
  logic [63:0] m0_addra, m1_addra, m0_dina, m1_dina;
  logic [7:0]  m0_wea, m1_wea;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [63:0] m0_douta, m1_douta;
  logic [63:0] s_addra, s_dina, s_douta;
  logic        s_ena;
  logic [7:0]  s_wea;

  logic [63:0] mem [0:255];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;

  typedef struct {
    logic        mst;
    logic [63:0] data;
    int          cyc;
  } sb_t;
  sb_t sb_q[$];

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_ena(m0_ena), .m0_addra(m0_addra), .m0_dina(m0_dina), .m0_wea(m0_wea),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_douta(m0_douta),
    .m1_ena(m1_ena), .m1_addra(m1_addra), .m1_dina(m1_dina), .m1_wea(m1_wea),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_douta(m1_douta),
    .s_addra(s_addra), .s_dina(s_dina), .s_ena(s_ena), .s_wea(s_wea),
    .s_douta(s_douta)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: byte-masked writes, reads return the pre-edge contents.
  always @(posedge clk) begin
    if (s_ena) begin
      if (s_wea == 8'h00) s_douta <= mem[s_addra[7:0]];
      for (int b = 0; b < 8; b++)
        if (s_wea[b]) mem[s_addra[7:0]][b*8 +: 8] <= s_dina[b*8 +: 8];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(
    input logic r,
    input logic e0, input logic [7:0] a0, input logic [63:0] d0, input logic [7:0] w0,
    input logic e1, input logic [7:0] a1, input logic [63:0] d1, input logic [7:0] w1,
    input logic g0, input logic g1, input logic [63:0] rd);
    sb_t e;
    @(posedge clk);
    #1;
    rst = r;
    m0_ena = e0; m0_addra = {56'h0, a0}; m0_dina = d0; m0_wea = w0;
    m1_ena = e1; m1_addra = {56'h0, a1}; m1_dina = d1; m1_wea = w1;
    @(negedge clk);
    checkOutput("gnt", {62'h0, m1_gnt, m0_gnt}, {62'h0, g1, g0});
    checkOutput("s_ena", {63'h0, s_ena}, {63'h0, (e0 | e1) & ~r});
    if (g0 && w0 == 8'h00) begin
      e.mst = 1'b0; e.data = rd; e.cyc = cyc; sb_q.push_back(e);
    end else if (g1 && w1 == 8'h00) begin
      e.mst = 1'b1; e.data = rd; e.cyc = cyc; sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    applyStimulus(0, 0, 8'h00, 64'h0, 8'h00, 0, 8'h00, 64'h0, 8'h00, 0, 0, 64'h0);
  endtask

  // Monitor: a response is due exactly one cycle after its grant.
  initial begin : monitor
    sb_t         e;
    logic        ev0, ev1;
    logic [63:0] edat;
    logic [63:0] hold0, hold1;
    hold0 = '0;
    hold1 = '0;
    forever begin
      @(negedge clk);
      #2;
      if (cyc >= 2) begin
        ev0 = 1'b0; ev1 = 1'b0; edat = '0;
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc - 1) begin
          e = sb_q.pop_front();
          if (!rst) begin
            ev0 = (e.mst == 1'b0);
            ev1 = (e.mst == 1'b1);
            edat = e.data;
          end
        end
        checkOutput("rvalid", {62'h0, m1_rvalid, m0_rvalid}, {62'h0, ev1, ev0});
        if (ev0) hold0 = edat;
        if (ev1) hold1 = edat;
        checkOutput("douta0", m0_douta, hold0);
        checkOutput("douta1", m1_douta, hold1);
        if (rst) begin
          hold0 = '0;
          hold1 = '0;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
    mem[8'h20] = 64'h0000_0000_0000_1234;
    s_douta = '0;
    rst = 1'b1;
    m0_ena = 0; m0_addra = '0; m0_dina = '0; m0_wea = '0;
    m1_ena = 0; m1_addra = '0; m1_dina = '0; m1_wea = '0;

    // Reset holds off grants even with both masters requesting.
    repeat (2) applyStimulus(1, 1, 8'h10, 64'h0, 8'h00, 1, 8'h11, 64'h0, 8'h00, 0, 0, 64'h0);

    // Lone m1 reads back to back.
    repeat (3) applyStimulus(0, 0, 8'h00, 64'h0, 8'h00, 1, 8'h80, 64'h0, 8'h00, 0, 1, 64'hC0DE_0000_0000_0080);
    idle();

    // First conflict after reset goes to m0; m1 holds and wins next.
    applyStimulus(1, 0, 8'h00, 64'h0, 8'h00, 0, 8'h00, 64'h0, 8'h00, 0, 0, 64'h0);
    applyStimulus(0, 1, 8'h40, 64'h0, 8'h00, 1, 8'h41, 64'h0, 8'h00, 1, 0, 64'hC0DE_0000_0000_0040);
    applyStimulus(0, 0, 8'h00, 64'h0, 8'h00, 1, 8'h41, 64'h0, 8'h00, 0, 1, 64'hC0DE_0000_0000_0041);

    // Continuous conflict for 6 cycles.
    for (int i = 0; i < 6; i++) begin
      if (!RR || (i % 2 == 0))
        applyStimulus(0, 1, 8'h50, 64'h0, 8'h00, 1, 8'h51, 64'h0, 8'h00, 1, 0, 64'hC0DE_0000_0000_0050);
      else
        applyStimulus(0, 1, 8'h50, 64'h0, 8'h00, 1, 8'h51, 64'h0, 8'h00, 0, 1, 64'hC0DE_0000_0000_0051);
    end
    idle();

    // Writes produce no rvalid; read-after-write and byte-masked writes.
    applyStimulus(0, 1, 8'h60, 64'h0000_0000_DEAD_BEEF, 8'hFF, 0, 8'h00, 64'h0, 8'h00, 1, 0, 64'h0);
    applyStimulus(0, 1, 8'h60, 64'h0, 8'h00, 0, 8'h00, 64'h0, 8'h00, 1, 0, 64'h0000_0000_DEAD_BEEF);
    applyStimulus(0, 0, 8'h00, 64'h0, 8'h00, 1, 8'h61, 64'h1111_2222_3333_4444, 8'h0F, 0, 1, 64'h0);
    applyStimulus(0, 0, 8'h00, 64'h0, 8'h00, 1, 8'h61, 64'h0, 8'h00, 0, 1, 64'hC0DE_0000_3333_4444);
    idle();

    // m1 result holds through idle cycles.
    applyStimulus(0, 0, 8'h00, 64'h0, 8'h00, 1, 8'h20, 64'h0, 8'h00, 0, 1, 64'h0000_0000_0000_1234);
    repeat (5) idle();

    // Reset right after a granted read kills its rvalid and clears holds.
    applyStimulus(0, 1, 8'h80, 64'h0, 8'h00, 0, 8'h00, 64'h0, 8'h00, 1, 0, 64'hC0DE_0000_0000_0080);
    applyStimulus(1, 1, 8'h80, 64'h0, 8'h00, 1, 8'h81, 64'h0, 8'h00, 0, 0, 64'h0);

    // First cycle out of reset arbitrates normally.
    applyStimulus(0, 1, 8'h41, 64'h0, 8'h00, 1, 8'h70, 64'h7777_0000_0000_0007, 8'hFF, 1, 0, 64'hC0DE_0000_0000_0041);
    applyStimulus(0, 0, 8'h00, 64'h0, 8'h00, 1, 8'h70, 64'h7777_0000_0000_0007, 8'hFF, 0, 1, 64'h0);
    applyStimulus(0, 0, 8'h00, 64'h0, 8'h00, 1, 8'h70, 64'h0, 8'h00, 0, 1, 64'h7777_0000_0000_0007);
    repeat (3) idle();

    checkOutput("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter LEN_ADDR, default 64, shall set the address width of all ports.
REQ-002 Parameter LEN_DATA, default 64, shall set the data width; LEN_DATA/8 shall set the byte-write-enable width.
REQ-003 Port clk  input  1  shall be the single clock; all state shall update on its rising edge.
REQ-004 Port rst  input  1  shall be the synchronous, active-high reset.
REQ-005 Ports m0_ena/m1_ena  input  1  shall be the per-master request; m0 is the data port, m1 the instruction port.
REQ-006 Ports m0_addra/m1_addra  input  LEN_ADDR  shall be the request address.
REQ-007 Ports m0_dina/m1_dina  input  LEN_DATA  shall be the write data.
REQ-008 Ports m0_wea/m1_wea  input  LEN_DATA/8  shall be byte write enables; all-zero means read.
REQ-009 Ports m0_gnt/m1_gnt  output  1  shall indicate the request is accepted this cycle.
REQ-010 Ports m0_rvalid/m1_rvalid  output  1  shall indicate that read data is valid this cycle.
REQ-011 Ports m0_douta/m1_douta  output  LEN_DATA  shall be the read data.
REQ-012 Ports s_addra, s_dina, s_ena, s_wea  output  shall drive one shared sram-style slave with 1-cycle read latency.
REQ-013 Port s_douta  input  LEN_DATA  shall be the slave read data.

Function
REQ-014 At most one gnt shall be high per cycle; gnt shall be combinational from same-cycle requests and state.
REQ-015 s_ena shall equal m0_ena|m1_ena; s_addra/s_dina/s_wea shall be muxed from the granted master and zero when none is granted.
REQ-016 If exactly one master requests, it shall be granted in that cycle, including on consecutive cycles.
REQ-017 On conflict, the grant shall follow the policy in REQ-027/REQ-028; the loser shall hold its request stable until granted, and there shall be no buffering.
REQ-018 A granted read in cycle N shall assert that master's rvalid for exactly cycle N+1, with douta equal to s_douta.
REQ-019 A granted write shall produce no rvalid.
REQ-020 Each master's douta shall hold its last rvalid data until that master's next rvalid; the register shall be per-master and 0 after reset.
REQ-021 A grant and an rvalid for a prior read may coincide for the same or different masters, with no bubble.
REQ-022 State shall be: last_gnt (1 bit), resp_pend (1 bit), resp_owner (1 bit), douta_hold[2]; there shall be no other state.

Reset
REQ-023 While rst is high, all gnt and rvalid shall be 0 and s_ena shall be 0, regardless of requests.
REQ-024 Reset shall set resp_pend=0, last_gnt=1, and douta_hold=0.
REQ-025 A read granted in the cycle rst rises shall produce no rvalid.
REQ-026 The first cycle after rst falls shall arbitrate normally.

Configuration
REQ-027 With SRAM_ARBITER_RR_EN defined, a conflict shall grant the master not in last_gnt; last_gnt shall update on every grant, so that after reset m0 wins the first conflict.
REQ-028 Without SRAM_ARBITER_RR_EN, m0 shall always win conflicts; last_gnt shall be removed.

Structure
REQ-029 A shared package sram_pkg shall hold the master-id typedef (M_DATA=0, M_INST=1) and the read/write encoding constant.
REQ-030 Grant selection shall be one combinational sub-module, arb_pick2, shared by both configurations.

Verification
REQ-031 Only m1 reads addr 0x80 for 3 consecutive cycles -> gnt1=1 each cycle; rvalid1 in cycles 2-4 with mem[0x80].
REQ-032 Both read in the same cycle, RR on, first after reset -> gnt0 first, gnt1 next cycle; rvalids one cycle apart.
REQ-033 Both request continuously for 6 cycles, RR on -> grants alternate 0,1,0,1,0,1; with RR off -> gnt0 all 6 cycles.
REQ-034 m0 writes 0xDEADBEEF with wea=0xFF, then reads the same address -> no rvalid for the write; the read returns 0xDEADBEEF.
REQ-035 m0 read granted, rst asserted next edge -> rvalid0=0 and douta0=0 after reset.
REQ-036 m1 read returns 0x1234, then m1 idles 5 cycles -> douta1 stays 0x1234 with rvalid1=0.
